seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 13 +
 rtl/seq_divider_cla.sv | 44 ++++
 rtl/seq_divider.sv | 144 ++++++++++++++
 tb/tb_seq_divider.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: the controller
// state encoding and the default operand width.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_cla.sv
// cla_subtractor: N-bit A-B computed as A + ~B + 1, with every carry formed
// directly from the generate/propagate terms (carry-lookahead), so no carry
// waits on a lower-order carry. Borrow is the inverted carry out.
module cla_subtractor #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] difference,
  output logic         borrow
);

  logic [N-1:0] w_bInv;
  logic [N-1:0] w_gen;
  logic [N-1:0] w_prop;
  logic [N:0]   w_carry;
  logic         w_cAcc;
  logic         w_pAcc;

  assign w_bInv = ~b;
  assign w_gen  = a & w_bInv;
  assign w_prop = a ^ w_bInv;

  // Expand each carry as G[i] | P[i]G[i-1] | ... | P[i]..P[0]Cin with Cin = 1
  always_comb begin
    w_carry    = '0;
    w_cAcc     = 1'b0;
    w_pAcc     = 1'b0;
    w_carry[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      w_cAcc = w_gen[i];
      w_pAcc = w_prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_cAcc = w_cAcc | (w_pAcc & w_gen[j]);
        w_pAcc = w_pAcc & w_prop[j];
      end
      w_carry[i+1] = w_cAcc | w_pAcc;
    end
  end

  assign difference = w_prop ^ w_carry[N-1:0];
  assign borrow     = ~w_carry[N];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per BUSY cycle, MSB first.
// A zero divisor short-circuits straight to DONE with all-ones quotient and
// the dividend as remainder. Results are held in dedicated output registers
// so they only change when a computation finishes.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_nextState;
  logic             w_inReady;
  logic             w_outValid;

  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_workRem;
  logic [WIDTH-2:0] r_workQuot;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_divByZero;

  logic [WIDTH:0]   w_trialA;
  logic [WIDTH:0]   w_trialB;
  logic [WIDTH:0]   w_difference;
  logic             w_borrow;
  logic             w_keepDiff;
  logic [WIDTH-1:0] w_newRem;
  logic [WIDTH-1:0] w_quotShift;

  // Shift the next dividend bit (selected by the down-counter) into the
  // partial remainder and trial-subtract the divisor in WIDTH+1 bits.
  assign w_trialA = {r_workRem, r_dividend[r_count]};
  assign w_trialB = {1'b0, r_divisor};

  cla_subtractor #(
    .N(WIDTH + 1)
  ) u_sub (
    .a         (w_trialA),
    .b         (w_trialB),
    .difference(w_difference),
    .borrow    (w_borrow)
  );

  // Without a borrow the difference is below the divisor, so its top bit is
  // zero; requiring that as well keeps the restore decision self-consistent.
  assign w_keepDiff  = ~w_borrow & ~w_difference[WIDTH];
  assign w_newRem    = w_keepDiff ? w_difference[WIDTH-1:0] : w_trialA[WIDTH-1:0];
  assign w_quotShift = {r_workQuot, w_keepDiff};

  // Controller state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state and handshake decode: accept only in IDLE, present only in DONE
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (in_valid) w_nextState = (divisor == '0) ? DONE : BUSY;
      end
      BUSY: begin
        if (r_count == '0) w_nextState = DONE;
      end
      DONE: begin
        w_outValid = 1'b1;
        if (out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Operand capture, one restoring step per BUSY cycle, result commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_workRem   <= '0;
      r_workQuot  <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divByZero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dividend <= dividend;
            r_divisor  <= divisor;
            r_workRem  <= '0;
            r_workQuot <= '0;
            r_count    <= CW'(WIDTH - 1);
            if (divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_divByZero <= 1'b1;
            end
          end
        end
        BUSY: begin
          r_workRem  <= w_newRem;
          r_workQuot <= w_quotShift[WIDTH-2:0];
          if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end else begin
            r_quotient  <= w_quotShift;
            r_remainder <= w_newRem;
            r_divByZero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready    = w_inReady;
  assign out_valid   = w_outValid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_divByZero;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): directed corner cases,
// a mid-operation reset, and randomized back-to-back divisions compared
// against plain integer division.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int vectorCount;
  int miscompareCount;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so a stuck design can never hang the run
  initial begin
    #5_000_000;
    $display("[TB] FAIL timeout: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] time limit reached");
  end

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One complete division transaction checked against integer arithmetic
  task automatic applyStimulus(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                               input int stallCycles, input bit toggleValid);
    int          waitCnt;
    int          lat;
    int          expLat;
    logic [W-1:0] expQ;
    logic [W-1:0] expR;
    logic        expZ;

    if (dvs == 0) begin
      expQ   = {W{1'b1}};
      expR   = dvd;
      expZ   = 1'b1;
      expLat = 1;
    end else begin
      expQ   = W'(int'(dvd) / int'(dvs));
      expR   = W'(int'(dvd) % int'(dvs));
      expZ   = 1'b0;
      expLat = W + 1;
    end

    waitCnt = 0;
    while (!in_ready && waitCnt < 50) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput("in_ready_before_transfer", 32'(in_ready), 32'd1);

    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      if (toggleValid) begin
        in_valid = 1'($urandom_range(0, 1));
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;

    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("out_valid", 32'(out_valid), 32'd1);
    checkOutput("in_ready_in_done", 32'(in_ready), 32'd0);
    checkOutput("quotient", 32'(quotient), 32'(expQ));
    checkOutput("remainder", 32'(remainder), 32'(expR));
    checkOutput("div_by_zero", 32'(div_by_zero), 32'(expZ));

    for (int s = 0; s < stallCycles; s++) begin
      if (toggleValid) begin
        in_valid = 1'($urandom_range(0, 1));
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      @(posedge clk); #1;
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_quotient", 32'(quotient), 32'(expQ));
      checkOutput("stall_remainder", 32'(remainder), 32'(expR));
      checkOutput("stall_div_by_zero", 32'(div_by_zero), 32'(expZ));
    end
    in_valid = 1'b0;

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("release_out_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_hold_quotient", 32'(quotient), 32'(expQ));
    checkOutput("idle_hold_remainder", 32'(remainder), 32'(expR));
  endtask

  // Test sequence
  initial begin
    logic [W-1:0] rDvd;
    logic [W-1:0] rDvs;
    vectorCount     = 0;
    miscompareCount = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_quotient", 32'(quotient), 32'd0);
    checkOutput("reset_remainder", 32'(remainder), 32'd0);
    checkOutput("reset_div_by_zero", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] directed cases");
    applyStimulus(8'd100, 8'd7, 0, 1'b0);
    applyStimulus(8'd255, 8'd1, 0, 1'b0);
    applyStimulus(8'd5, 8'd9, 0, 1'b0);
    applyStimulus(8'd42, 8'd0, 0, 1'b0);
    applyStimulus(8'd200, 8'd13, 3, 1'b0);

    $display("[TB] reset during BUSY");
    dividend = 8'd100;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy_before_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("busy_before_reset_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_quotient", 32'(quotient), 32'd0);
    checkOutput("midreset_remainder", 32'(remainder), 32'd0);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(8'd9, 8'd3, 0, 1'b0);

    $display("[TB] randomized back-to-back pairs");
    for (int n = 0; n < 1000; n++) begin
      rDvd = W'($urandom);
      rDvs = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
      applyStimulus(rDvd, rDvs, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
